// File: rtl/tinker_pkg.sv
// Shared widths, opcodes and types for the tinker fetch front end.
package tinker_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INSN_W = 32;
  localparam logic [4:0] OP_HALT = 5'h0F;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h2000;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [INSN_W-1:0] insn);
    return insn[31:27] == OP_HALT;
  endfunction

endpackage

// File: rtl/tinker_insn_fifo.sv
// Instruction queue between fetch and decode; power-of-two depth, flushable.
module tinker_insn_fifo
  import tinker_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage carries no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/tinker_fetch_unit.sv
// Sequential instruction fetch with redirect, halt detection and a decode queue.
module tinker_fetch_unit
  import tinker_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [INSN_W-1:0] mem_rsp_data,
  output logic              dec_valid,
  output logic [INSN_W-1:0] dec_insn,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  // Address of the next response that will be kept; responses return in order.
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] occupancy;
  fetch_entry_t     head;
  logic [CNT_W:0]   budget;
  logic             accept, drop, enq, deq;

  assign budget        = {1'b0, occupancy} + {1'b0, inflight_q};
  assign mem_req_valid = !reset && (state_q == StRun) && !redirect_valid
                         && (budget < (CNT_W + 1)'(DEPTH));
  assign mem_req_addr  = reset ? '0 : fetch_pc_q;

  assign accept = mem_req_valid && mem_req_ready;
  assign drop   = mem_rsp_valid && (discard_q != '0);
  assign deq    = dec_valid && dec_ready && !redirect_valid;
  assign enq    = mem_rsp_valid && (discard_q == '0) && !redirect_valid
                  && (!fifo_full || deq);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(mem_rsp_valid);
    discard_d  = discard_q;
    if (redirect_valid) begin
      // Everything still outstanding belongs to the abandoned path.
      state_d    = StRun;
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      discard_d  = inflight_q - CNT_W'(mem_rsp_valid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (drop)   discard_d  = discard_q - CNT_W'(1);
      if (enq) begin
        rsp_pc_d = rsp_pc_q + ADDR_W'(4);
        if (is_halt(mem_rsp_data)) state_d = StHalted;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  tinker_insn_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (enq),
    .push_entry('{pc: rsp_pc_q, insn: mem_rsp_data}),
    .pop       (deq),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  assign dec_valid = !fifo_empty;
  assign dec_insn  = head.insn;
  assign dec_pc    = head.pc;

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Randomized bench for tinker_fetch_unit against a queue-based transaction model.
module tb_tinker_fetch_unit;
  import tinker_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        dec_valid;
  logic [31:0] dec_insn;
  logic [63:0] dec_pc;
  logic        dec_ready = 1'b0;

  always #5 clk = ~clk;

  tinker_fetch_unit #(
    .RESET_PC(64'h2000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .dec_valid     (dec_valid),
    .dec_insn      (dec_insn),
    .dec_pc        (dec_pc),
    .dec_ready     (dec_ready)
  );

  typedef struct {
    logic [63:0] addr;
    bit          live;
    int unsigned due;
  } pend_t;

  typedef struct {
    logic [31:0] insn;
    logic [63:0] pc;
  } dq_t;

  // Reference: outstanding requests (dead after a redirect) and the decode queue.
  pend_t       pend[$];
  dq_t         decq[$];
  logic [63:0] m_pc;
  bit          m_run;
  logic [63:0] halt_addr = 64'h1;
  logic [63:0] redir_target = 64'h3000;
  int unsigned cyc = 0;
  int unsigned dut_acc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    if (a == halt_addr) return 32'h7800_0000;
    w = (a[31:0] * 32'h9E37_79B1) ^ 32'h0135_7A5B;
    if (w[31:27] == 5'h0F) w[27] = ~w[27];
    return w;
  endfunction

  task automatic model_reset();
    pend.delete();
    decq.delete();
    m_pc  = 64'h2000;
    m_run = 1'b1;
  endtask

  // Entered at a falling edge; leaves at a falling edge with reset released.
  task automatic apply_reset(input bit mid_cycle);
    if (mid_cycle) #2;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_req_ready  = 1'b0;
    dec_ready      = 1'b0;
    #1;
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_dec_insn", 64'(dec_insn), 64'd0);
    check("rst_dec_pc", dec_pc, 64'd0);
    check("rst_req_addr", mem_req_addr, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input int unsigned ready_pct, input int unsigned dr_pct,
                      input int unsigned lat_lo, input int unsigned lat_hi,
                      input int unsigned redir_pct, input bit force_redir);
    bit          rv, rdy, rsp, dr, ev;
    logic [63:0] rpc;
    pend_t       h;
    dq_t         e;
    rv  = force_redir || ($urandom_range(0, 99) < redir_pct);
    rpc = force_redir ? redir_target : 64'h3000 + 64'(4 * $urandom_range(0, 63));
    rdy = $urandom_range(0, 99) < ready_pct;
    dr  = $urandom_range(0, 99) < dr_pct;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_req_ready  = rdy;
    dec_ready      = dr;
    mem_rsp_valid  = rsp;
    mem_rsp_data   = rsp ? mem_word(pend[0].addr) : 32'($urandom);
    #1;
    ev = m_run && !rv && (decq.size() + pend.size() < DEPTH);
    check("req_valid", 64'(mem_req_valid), 64'(ev));
    check("req_addr", mem_req_addr, m_pc);
    check("dec_valid", 64'(dec_valid), 64'(decq.size() > 0));
    if (decq.size() > 0) begin
      check("dec_insn", 64'(dec_insn), 64'(decq[0].insn));
      check("dec_pc", dec_pc, decq[0].pc);
    end
    if (mem_req_valid && mem_req_ready) dut_acc++;
    @(posedge clk);
    h = '{addr: '0, live: 1'b0, due: 0};
    if (rsp) h = pend.pop_front();
    if (rv) begin
      decq.delete();
      foreach (pend[i]) pend[i].live = 1'b0;
      m_pc  = rpc;
      m_run = 1'b1;
    end else begin
      if (dr && decq.size() > 0) void'(decq.pop_front());
      if (rsp && h.live) begin
        e.insn = mem_word(h.addr);
        e.pc   = h.addr;
        decq.push_back(e);
        if (e.insn[31:27] == 5'h0F) m_run = 1'b0;
      end
      if (ev && rdy) begin
        pend.push_back('{addr: m_pc, live: 1'b1, due: cyc + 1 + $urandom_range(lat_lo, lat_hi)});
        m_pc = m_pc + 64'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    apply_reset(1'b0);

    // Streaming: full ready, 1-cycle responses, decode always ready.
    repeat (20) step(100, 100, 0, 0, 0, 1'b0);

    // Decode stalled: the queue budget caps requests; one dequeue frees one slot.
    apply_reset(1'b0);
    dut_acc = 0;
    repeat (10) step(100, 0, 0, 1, 0, 1'b0);
    check("stall_req_count", 64'(dut_acc), 64'd4);
    step(100, 100, 0, 0, 0, 1'b0);
    repeat (6) step(100, 0, 0, 0, 0, 1'b0);
    check("one_more_req", 64'(dut_acc), 64'd5);

    // Reset in the middle of a cycle with the queue full.
    apply_reset(1'b1);
    repeat (8) step(100, 100, 0, 0, 0, 1'b0);

    // Redirect with two requests outstanding.
    apply_reset(1'b0);
    repeat (2) step(100, 100, 2, 2, 0, 1'b0);
    redir_target = 64'h3000;
    step(100, 100, 2, 2, 0, 1'b1);
    repeat (15) step(100, 100, 2, 2, 0, 1'b0);

    // Halt word at 0x2008, then resume with a redirect.
    apply_reset(1'b0);
    halt_addr = 64'h2008;
    repeat (25) step(100, 50, 0, 1, 0, 1'b0);
    redir_target = 64'h2100;
    step(100, 50, 0, 1, 0, 1'b1);
    repeat (15) step(100, 100, 0, 1, 0, 1'b0);
    halt_addr = 64'h1;

    // Ready held low, then redirect colliding with a response and a dequeue.
    apply_reset(1'b0);
    step(100, 100, 0, 0, 0, 1'b0);
    repeat (3) step(0, 100, 0, 0, 0, 1'b0);
    repeat (6) step(100, 100, 0, 0, 0, 1'b0);
    redir_target = 64'h3400;
    step(100, 100, 0, 0, 0, 1'b1);
    repeat (10) step(100, 100, 0, 0, 0, 1'b0);

    // Random soak with occasional halts, redirects and resets.
    for (int blk = 0; blk < 30; blk++) begin
      int unsigned rp, dp, lh;
      rp = $urandom_range(30, 100);
      dp = $urandom_range(20, 100);
      lh = $urandom_range(0, 3);
      halt_addr = ($urandom_range(0, 2) == 0) ? 64'h3000 + 64'(4 * $urandom_range(0, 63))
                                              : 64'h1;
      if (blk % 10 == 9) apply_reset(1'b1);
      repeat (50) step(rp, dp, 0, lh, 4, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tinker_fetch_unit.md
TINKER_FETCH_UNIT -- requirements
Module: tinker_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h2000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the instruction queue depth; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port redirect_valid  input  1  branch/call/return redirect from execute.
REQ-006 SHALL have port redirect_pc  input  64  redirect target.
REQ-007 SHALL have port mem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port mem_req_addr  output  64  fetch byte address.
REQ-009 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-010 SHALL have port mem_rsp_valid  input  1  instruction word returned; responses arrive in request order, at least 1 cycle after acceptance.
REQ-011 SHALL have port mem_rsp_data  input  32  little-endian instruction word.
REQ-012 SHALL have port dec_valid  output  1  queue head valid toward decode.
REQ-013 SHALL have port dec_insn  output  32  queue-head instruction.
REQ-014 SHALL have port dec_pc  output  64  queue-head instruction address.
REQ-015 SHALL have port dec_ready  input  1  decode consumes the queue head.

Function
REQ-016 SHALL transfer a request only when mem_req_valid and mem_req_ready are both high; fetch_pc then advances by 4, and the in-flight count increments.
REQ-017 SHALL assert mem_req_valid only when state=RUN, redirect_valid=0, and occupancy+in-flight<DEPTH.
REQ-018 SHALL hold mem_req_addr equal to fetch_pc, and SHALL hold it stable while mem_req_valid=1 and mem_req_ready=0.
REQ-019 SHALL enqueue {mem_rsp_data, issued address} on each mem_rsp_valid when the discard count is 0; dec_valid SHALL rise 1 cycle after the response, with no bypass.
REQ-020 SHALL decrement the discard count and drop the word on each mem_rsp_valid when the discard count is greater than 0.
REQ-021 SHALL dequeue on dec_valid and dec_ready together; dec_insn and dec_pc SHALL be stable while dec_valid=1 and dec_ready=0.
REQ-022 SHALL, on redirect_valid: empty the queue; set fetch_pc=redirect_pc; set discard=in-flight (minus 1 if a response arrives in the same cycle); set state=RUN. The first request to redirect_pc SHALL follow on the next cycle.
REQ-023 SHALL give redirect priority over a simultaneous dequeue, enqueue or halt detection.
REQ-024 SHALL implement an FSM with states RUN and HALTED; RUN moves to HALTED when an enqueued word has [31:27]=5'h0F; HALTED moves to RUN only on redirect.
REQ-025 SHALL, in HALTED, issue no requests, while still draining in-flight responses and serving dec_ready.
REQ-026 SHALL size the occupancy, in-flight and discard counters at clog2(DEPTH+1) bits; none SHALL ever exceed DEPTH.
REQ-027 SHALL apply simultaneous enqueue and dequeue in the same cycle with occupancy unchanged, including when the queue is full.
REQ-028 SHALL wrap the queue pointers modulo DEPTH.

Reset
REQ-029 SHALL, on reset: fetch_pc=RESET_PC; state=RUN; queue empty; in-flight=0; discard=0.
REQ-030 SHALL hold all outputs at 0 during reset: mem_req_valid, dec_valid, dec_insn, dec_pc, and mem_req_addr (mem_req_addr shows RESET_PC once reset is released).
REQ-031 SHALL treat reset during outstanding requests as complete; responses to pre-reset requests SHALL NOT arrive, and the environment SHALL guarantee this.

Structure
REQ-032 SHALL take ADDR_W=64, INSN_W=32, OP_HALT=5'h0F and the default RESET_PC from shared package tinker_pkg.
REQ-033 SHALL place the queue in one sub-module, tinker_insn_fifo, parameterized by DEPTH, with push/pop/full/empty/count.

Verification
REQ-034 SHALL cover: reset release, ready=1, 1-cycle responses -> requests 0x2000, 0x2004, 0x2008, ...; dec_pc follows in order, one per cycle.
REQ-035 SHALL cover: dec_ready=0, DEPTH=4 -> exactly 4 requests issued, mem_req_valid low after that; one dequeue -> exactly one new request.
REQ-036 SHALL cover: redirect to 0x3000 with 2 requests in flight -> both responses dropped, queue empty, next request 0x3000, first dec_pc=0x3000.
REQ-037 SHALL cover: word 0x78000000 (halt) fetched at 0x2008 -> no further requests; queued words still delivered; redirect 0x2100 -> fetch resumes at 0x2100.
REQ-038 SHALL cover: mem_req_ready low for 3 cycles -> mem_req_addr held at 0x2004 throughout; redirect in the same cycle as a response plus a dequeue -> redirect wins, discard count correct.
REQ-039 SHALL cover: reset asserted mid-stream with a full queue -> dec_valid=0 asynchronously; after release, first request is 0x2000.
